// File: rtl/gpr_wb_writer_pkg.sv
// Shared types and constants for the GPR write-back path: register-file geometry,
// the write-back request record and the write-port grant source encoding.
package gpr_wb_writer_pkg;

  localparam int GPR_AW  = 5;
  localparam int XLEN    = 64;
  localparam int NUM_GPR = 32;

  typedef struct packed {
    logic [GPR_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;

  typedef enum logic [1:0] {
    GNT_NONE   = 2'd0,
    GNT_FIFO   = 2'd1,
    GNT_LSU    = 2'd2,
    GNT_BYPASS = 2'd3
  } gnt_src_t;

  function automatic logic is_x0(input logic [GPR_AW-1:0] rd);
    return (rd == 5'd0);
  endfunction

endpackage

// File: rtl/gpr_wb_writer_if.sv
// Valid/ready result channel from a producer (ALU or LSU) into the write-back stage.
interface gpr_wb_writer_if;
  import gpr_wb_writer_pkg::*;

  logic              valid;
  logic              ready;
  logic [GPR_AW-1:0] rd;
  logic [XLEN-1:0]   data;

  modport master (output valid, output rd, output data, input ready);
  modport slave  (input valid, input rd, input data, output ready);

endinterface

// File: rtl/gpr_wb_writer_chk.sv
// Simulation checks for the write-back scoreboard: a committed GPR write must
// always retire a previously registered issue.
module gpr_wb_writer_chk (
  input logic clk,
  input logic rst,
  input logic rf_we,
  input logic wb_cnt_zero
);

  property p_no_dec_underflow;
    @(posedge clk) disable iff (rst) rf_we |-> !wb_cnt_zero;
  endproperty

  a_no_dec_underflow: assert property (p_no_dec_underflow);

endmodule

// File: rtl/gpr_wb_writer_wb_fifo.sv
// Synchronous FIFO of write-back requests; pointers carry an extra wrap bit so
// full and empty are distinguished without a separate occupancy counter.
module wb_fifo
  import gpr_wb_writer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  wb_req_t wr_req,
  input  logic    pop,
  output wb_req_t head,
  output logic    full,
  output logic    empty
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW:0]   PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0] wr_ptr_r;
  logic [AW:0] rd_ptr_r;
  wb_req_t     mem_r [DEPTH];

  // Pointer and storage update; pushes are refused when full, pops when empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '{rd: 5'd0, data: 64'd0};
      end
    end else begin
      if (push && !full) begin
        mem_r[wr_ptr_r[AW-1:0]] <= wr_req;
        wr_ptr_r                <= wr_ptr_r + PTR_ONE;
      end
      if (pop && !empty) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  assign full  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign empty = (wr_ptr_r == rd_ptr_r);
  assign head  = mem_r[rd_ptr_r[AW-1:0]];

endmodule

// File: rtl/gpr_wb_writer.sv
// GPR write-back writer: arbitrates buffered ALU and LSU results onto the single
// register-file write port and tracks pending writes per register for decode.
module gpr_wb_writer
  import gpr_wb_writer_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 issue_valid,
  input  logic [GPR_AW-1:0]    issue_rd,
  output logic                 issue_ready,
  input  logic [GPR_AW-1:0]    busy_raddr1,
  output logic                 busy1,
  input  logic [GPR_AW-1:0]    busy_raddr2,
  output logic                 busy2,
  gpr_wb_writer_if.slave       alu,
  gpr_wb_writer_if.slave       lsu,
  output logic                 rf_we,
  output logic [GPR_AW-1:0]    rf_waddr,
  output logic [XLEN-1:0]      rf_wdata
);

  localparam logic [CNT_W-1:0]   CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]   CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1'b1);
  localparam logic [NUM_GPR-1:0] ONE_HOT0 = {{(NUM_GPR-1){1'b0}}, 1'b1};

  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic              fifo_push_s;
  logic              fifo_pop_s;
  wb_req_t           fifo_head_s;
  wb_req_t           alu_req_s;
  gnt_src_t          gnt_s;
  wb_req_t           gnt_req_s;

  logic              rf_we_r;
  logic [GPR_AW-1:0] rf_waddr_r;
  logic [XLEN-1:0]   rf_wdata_r;

  logic [CNT_W-1:0]   cnt_r [NUM_GPR];
  logic [NUM_GPR-1:0] inc_vec_s;
  logic [NUM_GPR-1:0] dec_vec_s;
  logic               issue_inc_s;
  logic               wb_cnt_zero_s;

  assign alu_req_s = '{rd: alu.rd, data: alu.data};

  wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (fifo_push_s),
    .wr_req (alu_req_s),
    .pop    (fifo_pop_s),
    .head   (fifo_head_s),
    .full   (fifo_full_s),
    .empty  (fifo_empty_s)
  );

  // Write-port grant: a full FIFO must drain before the LSU can progress.
  always_comb begin
    gnt_s     = GNT_NONE;
    gnt_req_s = fifo_head_s;
    if (fifo_full_s) begin
      gnt_s     = GNT_FIFO;
      gnt_req_s = fifo_head_s;
    end else if (lsu.valid) begin
      gnt_s     = GNT_LSU;
      gnt_req_s = '{rd: lsu.rd, data: lsu.data};
    end else if (!fifo_empty_s) begin
      gnt_s     = GNT_FIFO;
      gnt_req_s = fifo_head_s;
    end else if (alu.valid) begin
      gnt_s     = GNT_BYPASS;
      gnt_req_s = alu_req_s;
    end else begin
      gnt_s     = GNT_NONE;
      gnt_req_s = fifo_head_s;
    end
  end

  assign alu.ready   = !fifo_full_s;
  assign lsu.ready   = !fifo_full_s;
  assign fifo_push_s = alu.valid && !fifo_full_s && (gnt_s != GNT_BYPASS);
  assign fifo_pop_s  = (gnt_s == GNT_FIFO);

  // Registered GPR write port; results to x0 are consumed without a write.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we_r    <= 1'b0;
      rf_waddr_r <= 5'd0;
      rf_wdata_r <= 64'd0;
    end else if (gnt_s != GNT_NONE) begin
      rf_we_r    <= !is_x0(gnt_req_s.rd);
      rf_waddr_r <= gnt_req_s.rd;
      rf_wdata_r <= gnt_req_s.data;
    end else begin
      rf_we_r    <= 1'b0;
      rf_waddr_r <= rf_waddr_r;
      rf_wdata_r <= rf_wdata_r;
    end
  end

  assign rf_we    = rf_we_r;
  assign rf_waddr = rf_waddr_r;
  assign rf_wdata = rf_wdata_r;

  // A saturated counter still admits an issue when the same register retires now.
  always_comb begin
    issue_ready = 1'b0;
    if (is_x0(issue_rd)) begin
      issue_ready = 1'b1;
    end else if (cnt_r[issue_rd] != CNT_MAX) begin
      issue_ready = 1'b1;
    end else if (dec_vec_s[issue_rd]) begin
      issue_ready = 1'b1;
    end else begin
      issue_ready = 1'b0;
    end
  end

  assign issue_inc_s = issue_valid && issue_ready && !is_x0(issue_rd);
  assign inc_vec_s   = issue_inc_s ? (ONE_HOT0 << issue_rd) : {NUM_GPR{1'b0}};
  assign dec_vec_s   = rf_we_r ? (ONE_HOT0 << rf_waddr_r) : {NUM_GPR{1'b0}};

  // Pending-write counters; entry 0 never sees inc or dec, so x0 stays idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_GPR; r++) begin
        cnt_r[r] <= CNT_ZERO;
      end
    end else begin
      for (int r = 0; r < NUM_GPR; r++) begin
        case ({inc_vec_s[r], dec_vec_s[r]})
          2'b10:   cnt_r[r] <= cnt_r[r] + CNT_ONE;
          2'b01:   cnt_r[r] <= (cnt_r[r] != CNT_ZERO) ? (cnt_r[r] - CNT_ONE) : CNT_ZERO;
          default: cnt_r[r] <= cnt_r[r];
        endcase
      end
    end
  end

  assign busy1         = (cnt_r[busy_raddr1] != CNT_ZERO);
  assign busy2         = (cnt_r[busy_raddr2] != CNT_ZERO);
  assign wb_cnt_zero_s = (cnt_r[rf_waddr_r] == CNT_ZERO);

  gpr_wb_writer_chk u_chk (
    .clk         (clk),
    .rst         (rst),
    .rf_we       (rf_we_r),
    .wb_cnt_zero (wb_cnt_zero_s)
  );

endmodule

// File: tb/tb_gpr_wb_writer.sv
// Self-checking bench for gpr_wb_writer: single-result vectors from a table plus
// hand-written contention, FIFO-full, scoreboard and reset sequences.
module tb_gpr_wb_writer;
  import gpr_wb_writer_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_ready;
  logic [4:0]  busy_raddr1;
  logic [4:0]  busy_raddr2;
  logic        busy1;
  logic        busy2;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata;

  gpr_wb_writer_if alu_bus ();
  gpr_wb_writer_if lsu_bus ();

  gpr_wb_writer #(.FIFO_DEPTH(4), .CNT_W(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_ready (issue_ready),
    .busy_raddr1 (busy_raddr1),
    .busy1       (busy1),
    .busy_raddr2 (busy_raddr2),
    .busy2       (busy2),
    .alu         (alu_bus),
    .lsu         (lsu_bus),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata)
  );

  always #5 clk = ~clk;

  int      n_cmp = 0;
  int      n_bad = 0;
  wb_req_t exp_q[$];

  typedef struct {
    logic        use_lsu;
    logic [4:0]  rd;
    logic [63:0] data;
    logic        exp_we;
    logic        exp_busy;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance one clock and retire any observed GPR write against the scoreboard.
  task automatic tick();
    wb_req_t e;
    @(posedge clk);
    #1;
    if (rf_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got x%0d=%h expected no write", rf_waddr, rf_wdata);
      end else begin
        e = exp_q.pop_front();
        chk("wb_addr", {59'd0, rf_waddr}, {59'd0, e.rd});
        chk("wb_data", rf_wdata, e.data);
      end
    end
  endtask

  task automatic drive_alu(input logic v, input logic [4:0] rd, input logic [63:0] d);
    alu_bus.valid = v;
    alu_bus.rd    = rd;
    alu_bus.data  = d;
  endtask

  task automatic drive_lsu(input logic v, input logic [4:0] rd, input logic [63:0] d);
    lsu_bus.valid = v;
    lsu_bus.rd    = rd;
    lsu_bus.data  = d;
  endtask

  task automatic expect_wb(input logic [4:0] rd, input logic [63:0] d);
    exp_q.push_back('{rd: rd, data: d});
  endtask

  task automatic issue(input logic [4:0] rd);
    issue_valid = 1'b1;
    issue_rd    = rd;
    tick();
    issue_valid = 1'b0;
  endtask

  initial begin
    vecs[0] = '{use_lsu: 1'b0, rd: 5'd1,  data: 64'h0123_4567_89AB_CDEF, exp_we: 1'b1, exp_busy: 1'b1};
    vecs[1] = '{use_lsu: 1'b1, rd: 5'd2,  data: 64'hFFFF_0000_FFFF_0000, exp_we: 1'b1, exp_busy: 1'b1};
    vecs[2] = '{use_lsu: 1'b0, rd: 5'd31, data: 64'hFFFF_FFFF_FFFF_FFFF, exp_we: 1'b1, exp_busy: 1'b1};
    vecs[3] = '{use_lsu: 1'b1, rd: 5'd0,  data: 64'h0000_0000_0000_00AA, exp_we: 1'b0, exp_busy: 1'b0};
    vecs[4] = '{use_lsu: 1'b0, rd: 5'd0,  data: 64'h0000_0000_0000_00BB, exp_we: 1'b0, exp_busy: 1'b0};
    vecs[5] = '{use_lsu: 1'b1, rd: 5'd17, data: 64'h8000_0000_0000_0001, exp_we: 1'b1, exp_busy: 1'b1};

    // Reset held two cycles with every input active.
    rst = 1'b1;
    issue_valid = 1'b1;
    issue_rd    = 5'd9;
    busy_raddr1 = 5'd9;
    busy_raddr2 = 5'd3;
    drive_alu(1'b1, 5'd9, 64'h99);
    drive_lsu(1'b1, 5'd3, 64'h33);
    tick();
    tick();
    chk("rst_we", {63'd0, rf_we}, 64'd0);
    rst = 1'b0;
    issue_valid = 1'b0;
    drive_alu(1'b0, 5'd0, 64'd0);
    drive_lsu(1'b0, 5'd0, 64'd0);
    #1;
    chk("rst_busy1", {63'd0, busy1}, 64'd0);
    chk("rst_busy2", {63'd0, busy2}, 64'd0);
    chk("rst_alu_ready", {63'd0, alu_bus.ready}, 64'd1);
    chk("rst_waddr", {59'd0, rf_waddr}, 64'd0);
    chk("rst_wdata", rf_wdata, 64'd0);
    tick();
    chk("rst_fifo_empty_we", {63'd0, rf_we}, 64'd0);

    // Single-result vectors through ALU bypass or LSU.
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].rd != 5'd0) issue(vecs[i].rd);
      busy_raddr1 = vecs[i].rd;
      #1;
      chk("vec_busy_pending", {63'd0, busy1}, {63'd0, vecs[i].exp_busy});
      if (vecs[i].use_lsu) drive_lsu(1'b1, vecs[i].rd, vecs[i].data);
      else                 drive_alu(1'b1, vecs[i].rd, vecs[i].data);
      #1;
      chk("vec_ready", {63'd0, (vecs[i].use_lsu ? lsu_bus.ready : alu_bus.ready)}, 64'd1);
      if (vecs[i].exp_we) expect_wb(vecs[i].rd, vecs[i].data);
      tick();
      drive_alu(1'b0, 5'd0, 64'd0);
      drive_lsu(1'b0, 5'd0, 64'd0);
      chk("vec_we", {63'd0, rf_we}, {63'd0, vecs[i].exp_we});
      tick();
      chk("vec_busy_clear", {63'd0, busy1}, 64'd0);
    end

    // Bypass: busy through the write cycle, clear the cycle after.
    issue(5'd5);
    busy_raddr1 = 5'd5;
    drive_alu(1'b1, 5'd5, 64'hDEAD);
    expect_wb(5'd5, 64'hDEAD);
    #1;
    chk("byp_busy_before", {63'd0, busy1}, 64'd1);
    tick();
    drive_alu(1'b0, 5'd0, 64'd0);
    chk("byp_we", {63'd0, rf_we}, 64'd1);
    chk("byp_busy_write_cycle", {63'd0, busy1}, 64'd1);
    tick();
    chk("byp_busy_after", {63'd0, busy1}, 64'd0);

    // Contention: LSU first, buffered ALU on the next cycle.
    issue(5'd3);
    issue(5'd4);
    drive_alu(1'b1, 5'd3, 64'h11);
    drive_lsu(1'b1, 5'd4, 64'h22);
    expect_wb(5'd4, 64'h22);
    expect_wb(5'd3, 64'h11);
    tick();
    drive_alu(1'b0, 5'd0, 64'd0);
    drive_lsu(1'b0, 5'd0, 64'd0);
    chk("cont_first_addr", {59'd0, rf_waddr}, 64'd4);
    tick();
    chk("cont_second_we", {63'd0, rf_we}, 64'd1);
    tick();

    // FIFO full: LSU occupies the port while four ALU results queue up.
    for (int i = 0; i < 5; i++) issue(5'(10 + i));
    for (int i = 0; i < 5; i++) issue(5'(20 + i));
    for (int i = 0; i < 4; i++) expect_wb(5'(20 + i), 64'h1000 + 64'(i));
    expect_wb(5'd10, 64'hA000);
    expect_wb(5'd24, 64'h1004);
    for (int i = 1; i < 5; i++) expect_wb(5'(10 + i), 64'hA000 + 64'(i));
    for (int i = 0; i < 4; i++) begin
      drive_alu(1'b1, 5'(10 + i), 64'hA000 + 64'(i));
      drive_lsu(1'b1, 5'(20 + i), 64'h1000 + 64'(i));
      tick();
    end
    drive_alu(1'b1, 5'd14, 64'hA004);
    drive_lsu(1'b1, 5'd24, 64'h1004);
    #1;
    chk("full_alu_ready", {63'd0, alu_bus.ready}, 64'd0);
    chk("full_lsu_ready", {63'd0, lsu_bus.ready}, 64'd0);
    tick();
    chk("full_head_first", {59'd0, rf_waddr}, 64'd10);
    chk("full_lsu_ready_after_pop", {63'd0, lsu_bus.ready}, 64'd1);
    tick();
    drive_alu(1'b0, 5'd0, 64'd0);
    drive_lsu(1'b0, 5'd0, 64'd0);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    chk("full_drained", 64'(exp_q.size()), 64'd0);
    tick();

    // Scoreboard saturation and same-cycle issue/retire of x7.
    busy_raddr2 = 5'd7;
    issue_rd    = 5'd7;
    issue_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("sat_issue_ready", {63'd0, issue_ready}, 64'd1);
      tick();
    end
    chk("sat_4th_ready", {63'd0, issue_ready}, 64'd0);
    tick();
    issue_valid = 1'b0;
    chk("sat_busy", {63'd0, busy2}, 64'd1);
    drive_alu(1'b1, 5'd7, 64'h77);
    expect_wb(5'd7, 64'h77);
    tick();
    drive_alu(1'b0, 5'd0, 64'd0);
    issue_valid = 1'b1;
    #1;
    chk("sat_ready_on_dec", {63'd0, issue_ready}, 64'd1);
    tick();
    issue_valid = 1'b0;
    #1;
    chk("sat_cnt_unchanged", {63'd0, issue_ready}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      drive_alu(1'b1, 5'd7, 64'h70 + 64'(i));
      expect_wb(5'd7, 64'h70 + 64'(i));
      tick();
    end
    drive_alu(1'b0, 5'd0, 64'd0);
    tick();
    chk("sat_busy_clear", {63'd0, busy2}, 64'd0);

    // Mid-operation reset with two ALU results buffered.
    issue(5'd15);
    issue(5'd16);
    issue(5'd25);
    issue(5'd26);
    expect_wb(5'd25, 64'h2525);
    expect_wb(5'd26, 64'h2626);
    drive_alu(1'b1, 5'd15, 64'h1515);
    drive_lsu(1'b1, 5'd25, 64'h2525);
    tick();
    drive_alu(1'b1, 5'd16, 64'h1616);
    drive_lsu(1'b1, 5'd26, 64'h2626);
    tick();
    drive_alu(1'b0, 5'd0, 64'd0);
    drive_lsu(1'b0, 5'd0, 64'd0);
    busy_raddr1 = 5'd15;
    busy_raddr2 = 5'd16;
    #1;
    chk("mid_busy_before", {63'd0, busy1}, 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_we", {63'd0, rf_we}, 64'd0);
    chk("mid_busy1", {63'd0, busy1}, 64'd0);
    chk("mid_busy2", {63'd0, busy2}, 64'd0);
    busy_raddr1 = 5'd26;
    #1;
    chk("mid_busy_lsu_rd", {63'd0, busy1}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mid_fifo_empty_we", {63'd0, rf_we}, 64'd0);
    end

    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
